// File: rtl/imm_narrow_pkg.sv
// imm_narrow_pkg: field-select encoding and field width constants shared
// by the immediate narrowing pipeline and its range checker.
package imm_narrow_pkg;

  // Field kinds selectable through in_sel
  typedef enum logic [1:0] {
    SEL_DT  = 2'b00,  // 9-bit data-transfer address offset
    SEL_ALU = 2'b01,  // 12-bit ALU immediate
    SEL_CB  = 2'b10,  // 19-bit conditional-branch offset
    SEL_B   = 2'b11   // 26-bit unconditional-branch offset
  } sel_e;

  localparam int W_DT    = 9;
  localparam int W_ALU   = 12;
  localparam int W_CB    = 19;
  localparam int W_B     = 26;
  localparam int FIELD_W = 26;  // widest field; out_field is this wide
  localparam int NUM_SEL = 4;

  // Field width in bits for a given select code
  function automatic int sel_width(input logic [1:0] sel);
    case (sel_e'(sel))
      SEL_DT:  return W_DT;
      SEL_ALU: return W_ALU;
      SEL_CB:  return W_CB;
      default: return W_B;
    endcase
  endfunction

endpackage

// File: rtl/imm_fit_chk.sv
// imm_fit_chk: purely combinational range check. For each of the four field
// widths it extracts the low bits and decides whether the full operand is
// representable in that field, then the select picks one result.
// Signed check: every bit from w-1 upward equals the field sign bit.
// Unsigned check (uns=1): every bit from w upward is zero.
module imm_fit_chk
  import imm_narrow_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic [DW-1:0]      data,
  input  logic [1:0]         sel,
  input  logic               uns,
  output logic [FIELD_W-1:0] field,
  output logic               fits
);

  logic [FIELD_W-1:0] field_arr [NUM_SEL];
  logic [NUM_SEL-1:0] fits_arr;

  // One fixed-width extractor/checker per field kind
  generate
    for (genvar gi = 0; gi < NUM_SEL; gi++) begin : g_width
      localparam int W = sel_width(2'(gi));

      logic [DW-W:0]   sign_run;   // bits DW-1 .. W-1
      logic [DW-W-1:0] above;      // bits DW-1 .. W
      logic            signed_ok;
      logic            unsigned_ok;

      assign sign_run    = data[DW-1:W-1];
      assign above       = data[DW-1:W];
      assign signed_ok   = (&sign_run) | ~(|sign_run);
      assign unsigned_ok = ~(|above);

      assign field_arr[gi] = FIELD_W'(data[W-1:0]);
      assign fits_arr[gi]  = uns ? unsigned_ok : signed_ok;
    end
  endgenerate

  assign field = field_arr[sel];
  assign fits  = fits_arr[sel];

endmodule

// File: rtl/imm_narrow.sv
// imm_narrow: two-stage valid/ready pipeline narrowing a DW-bit operand to
// a 9/12/19/26-bit instruction field, flagging whether it fits, and counting
// delivered results that did not fit (saturating, clearable).
// Stage 1 registers the operand; the range check sits between the stages;
// stage 2 registers field/fits/sel and drives the outputs.
// Optional macro IMM_NARROW_UNSIGNED_EN adds the in_uns port selecting an
// unsigned range check per transaction; without it the check is signed.
module imm_narrow
  import imm_narrow_pkg::*;
#(
  parameter int DW    = 64,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  input  logic [1:0]         in_sel,
`ifdef IMM_NARROW_UNSIGNED_EN
  input  logic               in_uns,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIELD_W-1:0] out_field,
  output logic               out_fits,
  output logic [1:0]         out_sel,
  output logic [CNT_W-1:0]   ovf_cnt,
  input  logic               cnt_clr
);

  logic               s1_valid_reg;
  logic [DW-1:0]      s1_data_reg;
  logic [1:0]         s1_sel_reg;
  logic               s1_uns;

  logic               s2_valid_reg;
  logic [FIELD_W-1:0] s2_field_reg;
  logic               s2_fits_reg;
  logic [1:0]         s2_sel_reg;

  logic [CNT_W-1:0]   cnt_reg;

  logic               s1_adv;
  logic               s2_adv;
  logic [FIELD_W-1:0] chk_field;
  logic               chk_fits;
  logic               ovf_event;

  // A stage may load when it is empty or its content is moving on; in_ready
  // is therefore a function of pipeline state and out_ready only.
  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;

  // Stage 1: capture operand and select
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_sel_reg   <= '0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      s1_data_reg  <= in_data;
      s1_sel_reg   <= in_sel;
    end
  end

`ifdef IMM_NARROW_UNSIGNED_EN
  logic s1_uns_reg;

  // Stage 1: the unsigned flag travels with its operand
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_uns_reg <= 1'b0;
    end else if (s1_adv) begin
      s1_uns_reg <= in_uns;
    end
  end

  assign s1_uns = s1_uns_reg;
`else
  assign s1_uns = 1'b0;
`endif

  imm_fit_chk #(
    .DW (DW)
  ) u_fit_chk (
    .data  (s1_data_reg),
    .sel   (s1_sel_reg),
    .uns   (s1_uns),
    .field (chk_field),
    .fits  (chk_fits)
  );

  // Stage 2: capture the checked result; holds steady while out_ready is low
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_reg <= 1'b0;
      s2_field_reg <= '0;
      s2_fits_reg  <= 1'b0;
      s2_sel_reg   <= '0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      s2_field_reg <= chk_field;
      s2_fits_reg  <= chk_fits;
      s2_sel_reg   <= s1_sel_reg;
    end
  end

  // A misfit counts only when the consumer actually takes it
  assign ovf_event = s2_valid_reg && out_ready && !s2_fits_reg;

  // Overflow counter: clear wins over increment, sticks at all-ones
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      cnt_reg <= '0;
    end else if (ovf_event && !(&cnt_reg)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_field = s2_field_reg;
  assign out_fits  = s2_fits_reg;
  assign out_sel   = s2_sel_reg;
  assign ovf_cnt   = cnt_reg;

endmodule

// File: tb/tb_imm_narrow.sv
// tb_imm_narrow: scoreboard bench for imm_narrow. Expected results are
// computed from a numeric range model when an operand is accepted and
// compared in order when a result is delivered; the overflow count is
// modelled alongside and compared every cycle.
module tb_imm_narrow;

  localparam int DW    = 64;
  localparam int CNT_W = 16;
`ifdef IMM_NARROW_UNSIGNED_EN
  localparam bit UNS_EN = 1'b1;
`else
  localparam bit UNS_EN = 1'b0;
`endif

  typedef struct {
    logic [25:0] field;
    logic        fits;
    logic [1:0]  sel;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [1:0]       in_sel;
  logic             in_uns;
  logic             out_valid;
  logic             out_ready;
  logic [25:0]      out_field;
  logic             out_fits;
  logic [1:0]       out_sel;
  logic [CNT_W-1:0] ovf_cnt;
  logic             cnt_clr;

  exp_t             sb [$];
  logic [CNT_W-1:0] exp_cnt;
  int               n_checks;
  int               n_errors;
  int               n_out;
  bit               verbose;
  bit               rand_ready;

  imm_narrow #(
    .DW    (DW),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
`ifdef IMM_NARROW_UNSIGNED_EN
    .in_uns    (in_uns),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_field (out_field),
    .out_fits  (out_fits),
    .out_sel   (out_sel),
    .ovf_cnt   (ovf_cnt),
    .cnt_clr   (cnt_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Range model: signed value must lie in [-2^(w-1), 2^(w-1)-1]
  function automatic exp_t model(input logic [63:0] d, input logic [1:0] s, input logic u);
    exp_t        e;
    int          w;
    longint      sd;
    longint      hi;
    longint      lo;
    logic [63:0] mask;
    case (s)
      2'b00:   w = 9;
      2'b01:   w = 12;
      2'b10:   w = 19;
      default: w = 26;
    endcase
    sd   = $signed(d);
    hi   = (longint'(1) <<< (w - 1)) - 1;
    lo   = -(longint'(1) <<< (w - 1));
    mask = (64'd1 << w) - 64'd1;
    e.field = 26'(d & mask);
    e.fits  = (sd >= lo) && (sd <= hi);
    if (u && UNS_EN) e.fits = (d <= mask);
    e.sel = s;
    return e;
  endfunction

  // Monitor: sample between edges, pop/compare deliveries, push acceptances
  always @(negedge clk) begin
    exp_t e;
    bit   xfer_out;
    if (reset) begin
      exp_cnt = '0;
    end else begin
      check("ovf_cnt", 64'(ovf_cnt), 64'(exp_cnt));
      xfer_out = out_valid && out_ready;
      e.fits = 1'b1;
      if (xfer_out) begin
        n_out++;
        if (sb.size() == 0) begin
          check("unexpected_out", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          check("out_field", 64'(out_field), 64'(e.field));
          check("out_fits", 64'(out_fits), 64'(e.fits));
          check("out_sel", 64'(out_sel), 64'(e.sel));
          if (verbose)
            $display("OUT #%0d sel=%0d field=%h fits=%0d", n_out, out_sel, out_field, out_fits);
        end
      end
      if (cnt_clr) exp_cnt = '0;
      else if (xfer_out && !e.fits && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
      if (in_valid && in_ready) sb.push_back(model(in_data, in_sel, in_uns));
    end
  end

  // Offer one operand until it is accepted (bounded)
  task automatic send(input logic [63:0] d, input logic [1:0] s, input logic u);
    bit ok;
    int tries;
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    in_uns   = u;
    tries    = 0;
    do begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!ok && tries < 1000);
    if (!ok) check("send_timeout", 64'(1), 64'(0));
    in_valid = 1'b0;
  endtask

  // Idle until every expected result has been delivered (bounded)
  task automatic drain();
    int cyc;
    in_valid   = 1'b0;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    cyc = 0;
    while ((sb.size() != 0 || out_valid) && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (sb.size() != 0 || out_valid) check("drain_timeout", 64'(1), 64'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          n0;
    int          w;
    logic [63:0] hi64;
    logic [63:0] d;
    logic [31:0] r;
    logic [CNT_W-1:0] c0;

    n_checks = 0; n_errors = 0; n_out = 0;
    verbose = 1'b1; rand_ready = 1'b0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; in_uns = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_ovf_cnt", 64'(ovf_cnt), 64'(0));
    check("rst_out_field", 64'(out_field), 64'(0));
    check("rst_out_fits", 64'(out_fits), 64'(0));
    check("rst_out_sel", 64'(out_sel), 64'(0));

    // Largest positive CB offset, with latency measurement
    send(64'h3FFFF, 2'b10, 1'b0);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(2));
    drain();

    // One past the positive CB limit increments the overflow count
    c0 = exp_cnt;
    send(64'h40000, 2'b10, 1'b0);
    drain();
    check("ovf_inc", 64'(ovf_cnt), 64'(c0 + 1'b1));

    // DT address: -256 fits, -257 does not
    send(64'hFFFF_FFFF_FFFF_FF00, 2'b00, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FEFF, 2'b00, 1'b0);
    drain();

    // Boundary values for every width, streamed back to back
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: w = 9;
        1: w = 12;
        2: w = 19;
        default: w = 26;
      endcase
      hi64 = (64'd1 << (w - 1)) - 64'd1;
      send(hi64, 2'(s), 1'b0);
      send(hi64 + 64'd1, 2'(s), 1'b0);
      send(~hi64, 2'(s), 1'b0);
      send(~hi64 - 64'd1, 2'(s), 1'b0);
      send(64'd0, 2'(s), 1'b0);
      send(~64'd0, 2'(s), 1'b0);
    end
    drain();

    // Random operands with random consumer back-pressure
    verbose = 1'b0;
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      case ($urandom_range(0, 2))
        0:       d = {$urandom, $urandom};
        1:       d = {{40{r[23]}}, r[23:0]};
        default: d = {{52{r[11]}}, r[11:0]};
      endcase
      send(d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    drain();
    verbose = 1'b1;

    // Stall: two operands buffer, third is refused, then all five drain
    n0 = n_out;
    out_ready = 1'b0;
    send(64'd1, 2'b01, 1'b0);
    send(64'd2047, 2'b01, 1'b0);
    in_valid = 1'b1;
    in_data  = 64'd2048;
    in_sel   = 2'b01;
    repeat (2) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(64'd2048, 2'b01, 1'b0);
    send(64'hFFFF_FFFF_FFFF_F800, 2'b01, 1'b0);
    send(64'hFFFF_FFFF_FFFF_F7FF, 2'b01, 1'b0);
    drain();
    check("stall_count", 64'(n_out - n0), 64'(5));

    // Reset with two results buffered: nothing stale may appear afterwards
    out_ready = 1'b0;
    send(64'h40000, 2'b10, 1'b0);
    send(64'h12345, 2'b11, 1'b0);
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_ovf_cnt", 64'(ovf_cnt), 64'(0));
    reset = 1'b0;
    out_ready = 1'b1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    n0 = n_out;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_no_stale", 64'(n_out - n0), 64'(0));

    // Saturation: fill the counter, confirm it sticks, then clear
    verbose = 1'b0;
    for (int i = 0; i < 65535; i++) send(64'h40000, 2'b10, 1'b0);
    drain();
    check("sat_full", 64'(ovf_cnt), 64'hFFFF);
    send(64'h40000, 2'b10, 1'b0);
    drain();
    check("sat_hold", 64'(ovf_cnt), 64'hFFFF);
    verbose = 1'b1;
    send(64'h40000, 2'b10, 1'b0);
    @(posedge clk);
    #1;
    check("clr_align_valid", 64'(out_valid), 64'(1));
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check("clr_priority", 64'(ovf_cnt), 64'(0));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
